// File: rtl/timer_irq_source_if.sv
// Data-memory bus seen by the timer peripheral: address, write data,
// read/write strobes from the control unit and combinational read data back.
interface timer_irq_source_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output MemRd, output MemWr, input rdata);
  modport slave  (input addr, input wdata, input MemRd, input MemWr, output rdata);
endinterface

// File: rtl/timer_irq_source.sv
// Memory-mapped timer: reload (TH), counter (TL), control/status (TCON)
// and a free-running cycle counter (SYSTICK). TL counts prescaled ticks and
// reloads from TH on overflow; a pending bit raises a level IRQ until cleared.
module timer_irq_source #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_irq_source_if.slave    bus,
  output logic                 IRQ
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

  localparam logic [31:0] ADDR_TH      = BASE_ADDR + 32'h00;
  localparam logic [31:0] ADDR_TL      = BASE_ADDR + 32'h04;
  localparam logic [31:0] ADDR_TCON    = BASE_ADDR + 32'h08;
  localparam logic [31:0] ADDR_SYSTICK = BASE_ADDR + 32'h14;

  logic [31:0]   th_q, th_d;
  logic [31:0]   tl_q, tl_d;
  logic [2:0]    tcon_q, tcon_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [31:0]   systick_q, systick_d;

  logic wr_th, wr_tl, wr_tcon;
  logic tick, overflow;
  logic hw_set;

  // Write decode, prescaler tick and overflow detection (all from pre-edge state)
  always_comb begin
    wr_th    = bus.MemWr && (bus.addr == ADDR_TH);
    wr_tl    = bus.MemWr && (bus.addr == ADDR_TL);
    wr_tcon  = bus.MemWr && (bus.addr == ADDR_TCON);
    tick     = tcon_q[0] && (pcnt_q == PCNT_MAX);
    overflow = tick && (tl_q == 32'hFFFF_FFFF);
    hw_set   = overflow && tcon_q[1];
  end

  // Next-state computation for every register
  always_comb begin
    th_d      = wr_th ? bus.wdata : th_q;
    systick_d = systick_q + 32'd1;

    // A software write to TL takes priority over the hardware count.
    tl_d = tl_q;
    if (wr_tl) begin
      tl_d = bus.wdata;
    end else if (tick) begin
      tl_d = overflow ? th_q : (tl_q + 32'd1);
    end

    // The hardware pending-set is OR-ed in even on a TCON write so it is never lost.
    if (wr_tcon) begin
      tcon_d = {bus.wdata[2] | hw_set, bus.wdata[1:0]};
    end else begin
      tcon_d = {tcon_q[2] | hw_set, tcon_q[1:0]};
    end

    // Disabling the counter (held or just written off) parks the prescaler at 0,
    // so re-enabling always waits a full PRESCALE period for the next tick.
    if (!tcon_q[0] || (wr_tcon && !bus.wdata[0]) || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      pcnt_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      pcnt_q    <= pcnt_d;
      systick_q <= systick_d;
    end
  end

  // Combinational read mux; anything unmapped or without MemRd reads 0
  always_comb begin
    bus.rdata = '0;
    if (bus.MemRd) begin
      case (bus.addr)
        ADDR_TH:      bus.rdata = th_q;
        ADDR_TL:      bus.rdata = tl_q;
        ADDR_TCON:    bus.rdata = {29'd0, tcon_q};
        ADDR_SYSTICK: bus.rdata = systick_q;
        default:      bus.rdata = '0;
      endcase
    end
  end

  assign IRQ = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed bench: one DUT with PRESCALE=1 (overflow, collisions, decode, reset)
// and one with PRESCALE=4 (prescaler behaviour).
module tb_timer_irq_source;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TH  = BASE + 32'h00;
  localparam logic [31:0] A_TL  = BASE + 32'h04;
  localparam logic [31:0] A_TC  = BASE + 32'h08;
  localparam logic [31:0] A_ST  = BASE + 32'h14;

  logic clk;
  logic reset;
  logic irq_a, irq_b;
  int   errors = 0;
  int   checks = 0;

  timer_irq_source_if bus_a ();
  timer_irq_source_if bus_b ();

  timer_irq_source #(.PRESCALE(1), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .IRQ(irq_a)
  );

  timer_irq_source #(.PRESCALE(4), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .IRQ(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [31:0] a, input logic [31:0] d);
    if (!sel) begin
      bus_a.addr = a; bus_a.wdata = d; bus_a.MemWr = 1'b1;
    end else begin
      bus_b.addr = a; bus_b.wdata = d; bus_b.MemWr = 1'b1;
    end
    step();
    bus_a.MemWr = 1'b0;
    bus_b.MemWr = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    if (!sel) begin
      bus_a.addr = a; bus_a.MemRd = 1'b1;
    end else begin
      bus_b.addr = a; bus_b.MemRd = 1'b1;
    end
    #1;
    v = sel ? bus_b.rdata : bus_a.rdata;
    bus_a.MemRd = 1'b0;
    bus_b.MemRd = 1'b0;
    check(tag, v, exp);
  endtask

  initial begin
    reset = 1'b1;
    bus_a.addr = '0; bus_a.wdata = '0; bus_a.MemRd = 1'b0; bus_a.MemWr = 1'b0;
    bus_b.addr = '0; bus_b.wdata = '0; bus_b.MemRd = 1'b0; bus_b.MemWr = 1'b0;
    #1;
    check("rst_irq", {31'd0, irq_a}, 32'd0);
    rd(0, A_TH, 32'd0, "rst_th");
    rd(0, A_TL, 32'd0, "rst_tl");
    rd(0, A_TC, 32'd0, "rst_tcon");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ---------------- basic overflow, PRESCALE=1 ----------------
    wr(0, A_TH, 32'hFFFF_FFFC);
    wr(0, A_TL, 32'hFFFF_FFFC);
    wr(0, A_TC, 32'h3);
    rd(0, A_TL, 32'hFFFF_FFFC, "ov_tl0");
    step(); rd(0, A_TL, 32'hFFFF_FFFD, "ov_tl1");
    step(); rd(0, A_TL, 32'hFFFF_FFFE, "ov_tl2");
    step(); rd(0, A_TL, 32'hFFFF_FFFF, "ov_tl3");
    check("ov_irq_pre", {31'd0, irq_a}, 32'd0);
    step(); rd(0, A_TL, 32'hFFFF_FFFC, "ov_reload");
    rd(0, A_TC, 32'h7, "ov_tcon");
    check("ov_irq", {31'd0, irq_a}, 32'd1);
    // Clear pending; counting continues through the write edge
    wr(0, A_TC, 32'h3);
    check("clr_irq", {31'd0, irq_a}, 32'd0);
    rd(0, A_TL, 32'hFFFF_FFFD, "clr_tl");
    step(); step(); step();
    rd(0, A_TL, 32'hFFFF_FFFC, "rep_reload");
    check("rep_irq", {31'd0, irq_a}, 32'd1);

    // ---------------- collision: TCON write at overflow ----------------
    wr(0, A_TC, 32'h3);                 // TL -> FFFD, pending cleared
    step(); step();                     // TL -> FFFE, FFFF
    check("col_irq_pre", {31'd0, irq_a}, 32'd0);
    wr(0, A_TC, 32'h3);                 // overflow edge
    rd(0, A_TC, 32'h7, "col_tcon");
    check("col_irq", {31'd0, irq_a}, 32'd1);
    rd(0, A_TL, 32'hFFFF_FFFC, "col_tc_tl");

    // ---------------- collision: TL write at overflow ----------------
    step(); step(); step();             // FFFD, FFFE, FFFF
    wr(0, A_TL, 32'h10);                // overflow edge, write wins
    rd(0, A_TL, 32'h10, "col_tl");

    // ---------------- collision: TH write at overflow ----------------
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TH, 32'h20);                // overflow edge: old TH reloads
    rd(0, A_TL, 32'hFFFF_FFFC, "col_th_tl");
    rd(0, A_TH, 32'h20, "col_th_th");

    // ---------------- interrupt disabled ----------------
    wr(0, A_TC, 32'h0);
    check("dis_irq0", {31'd0, irq_a}, 32'd0);
    wr(0, A_TH, 32'hFFFF_FFFE);
    wr(0, A_TL, 32'hFFFF_FFFE);
    wr(0, A_TC, 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("dis_irq", {31'd0, irq_a}, 32'd0);
    end
    rd(0, A_TL, 32'hFFFF_FFFE, "dis_tl");
    rd(0, A_TC, 32'h1, "dis_tcon");

    // ---------------- prescaler, PRESCALE=4 ----------------
    wr(1, A_TC, 32'h1);
    step(); step(); step();
    rd(1, A_TL, 32'd0, "ps_tl_3");
    step();
    rd(1, A_TL, 32'd1, "ps_tl_4");
    step(); step(); step(); step();
    rd(1, A_TL, 32'd2, "ps_tl_8");
    step(); step();                     // prescaler mid-count
    wr(1, A_TC, 32'h0);
    for (int i = 0; i < 5; i++) step();
    rd(1, A_TL, 32'd2, "ps_frozen");
    wr(1, A_TC, 32'h1);
    step(); step(); step();
    rd(1, A_TL, 32'd2, "ps_reen_3");
    step();
    rd(1, A_TL, 32'd3, "ps_reen_4");

    // ---------------- reset mid-run ----------------
    wr(0, A_TC, 32'h0);
    wr(0, A_TL, 32'd5);
    wr(0, A_TC, 32'h7);
    rd(0, A_TL, 32'd5, "pre_rst_tl");
    check("pre_rst_irq", {31'd0, irq_a}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_irq", {31'd0, irq_a}, 32'd0);
    rd(0, A_TL, 32'd0, "mid_rst_tl");
    rd(0, A_TC, 32'd0, "mid_rst_tcon");
    rd(0, A_ST, 32'd0, "mid_rst_st");
    @(posedge clk);
    #1 reset = 1'b0;

    // ---------------- bus decode ----------------
    rd(0, 32'h4000_000C, 32'd0, "dec_0c");
    rd(0, 32'h4000_0010, 32'd0, "dec_10");
    rd(0, 32'h0000_0008, 32'd0, "dec_low");
    wr(0, A_ST, 32'h1234);              // systick 1, write ignored
    wr(0, A_TL, 32'd7);                 // systick 2
    step();                             // systick 3
    rd(0, A_ST, 32'd3, "st_wr_ign");
    rd(0, A_TL, 32'd7, "dec_tl");
    bus_a.addr  = A_TL;
    bus_a.MemRd = 1'b0;
    #1;
    check("dec_nord", bus_a.rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
